// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle po_flag / frame_err strobes.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx #(
    parameter int UART_BPS = 'd9600,
    parameter int CLK_FREQ = 'd24_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       work_en
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int HALF         = BAUD_CNT_MAX / 2;
    localparam logic [12:0] CNT_LAST = 13'(BAUD_CNT_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_s3;
    logic [12:0] baud_cnt_reg;
    logic [3:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;
    logic        sample_tick;
    logic        bit_val;
    logic        load_data;
    logic        err_pulse;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // baud_cnt restarts from 0 on the edge leaving IDLE and then free-runs for the
    // whole frame, so every sample lands exactly BAUD_CNT_MAX edges after the last.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_cnt_reg <= 13'd0;
        end else if (state_reg == IDLE) begin
            baud_cnt_reg <= 13'd0;
        end else if (baud_cnt_reg == CNT_LAST) begin
            baud_cnt_reg <= 13'd0;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + 13'd1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Votes are the rx_s2 values on the edges where baud_cnt reaches HALF-1, HALF
    // and HALF+1; the decision is made on the HALF+1 edge.
    localparam logic [12:0] CNT_VOTE_A = 13'(HALF - 2);
    localparam logic [12:0] CNT_VOTE_B = 13'(HALF - 1);
    localparam logic [12:0] CNT_DECIDE = 13'(HALF);

    logic vote_a_reg;
    logic vote_b_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vote_a_reg <= 1'b1;
            vote_b_reg <= 1'b1;
        end else begin
            if (baud_cnt_reg == CNT_VOTE_A) begin
                vote_a_reg <= rx_s2;
            end
            if (baud_cnt_reg == CNT_VOTE_B) begin
                vote_b_reg <= rx_s2;
            end
        end
    end

    assign sample_tick = (state_reg != IDLE) && (baud_cnt_reg == CNT_DECIDE);
    assign bit_val     = (vote_a_reg & vote_b_reg) | (vote_a_reg & rx_s2) | (vote_b_reg & rx_s2);
`else
    // Sample on the edge where baud_cnt reaches HALF.
    localparam logic [12:0] CNT_SAMPLE = 13'(HALF - 1);

    assign sample_tick = (state_reg != IDLE) && (baud_cnt_reg == CNT_SAMPLE);
    assign bit_val     = rx_s2;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_data  = 1'b0;
        err_pulse  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_s3 && !rx_s2) begin
                    state_next = START;
                end
            end
            START: begin
                // A start bit that reads high at its centre was a glitch.
                if (sample_tick) begin
                    state_next = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_tick && (bit_cnt_reg == 4'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (sample_tick) begin
                    state_next = IDLE;
                    load_data  = bit_val;
                    err_pulse  = !bit_val;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 8'h00;
        end else if (state_reg != DATA) begin
            bit_cnt_reg <= 4'd0;
        end else if (sample_tick) begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            shift_reg   <= {bit_val, shift_reg[7:1]};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            po_data   <= 8'h00;
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            po_flag   <= load_data;
            frame_err <= err_pulse;
            if (load_data) begin
                po_data <= shift_reg;
            end
        end
    end

    assign work_en = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_CNT_MAX=10, HALF=5; stimulus and checks are aligned to negedges.
module tb_uart_rx;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT       = 98;
    localparam int GLITCH_WE = 6;
`else
    localparam int LAT       = 97;
    localparam int GLITCH_WE = 5;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;
    logic       work_en;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_e0 = 0;
    int we_cnt = 0;
    int both_cnt = 0;
    int flag_cyc_q[$];
    logic [7:0] flag_data_q[$];
    int err_cyc_q[$];

    uart_rx #(
        .UART_BPS(100_000),
        .CLK_FREQ(1_000_000)
    ) dut (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .rx(rx),
        .po_data(po_data),
        .po_flag(po_flag),
        .frame_err(frame_err),
        .work_en(work_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (po_flag) begin
            flag_cyc_q.push_back(cyc);
            flag_data_q.push_back(po_data);
        end
        if (frame_err) err_cyc_q.push_back(cyc);
        if (po_flag && frame_err) both_cnt++;
        if (work_en) we_cnt++;
    end

    task automatic clear_obs();
        flag_cyc_q.delete();
        flag_data_q.delete();
        err_cyc_q.delete();
        we_cnt = 0;
        both_cnt = 0;
    endtask

    // Called on a negedge; returns on a negedge with the line idle high.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        last_e0 = cyc + 1;
        $display("tx frame data=0x%02h stop=%0b e0=%0d", d, stop, last_e0);
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (10) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({po_data, po_flag, frame_err, work_en} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_in: got data=%02h flag=%b err=%b we=%b want 00 0 0 0", po_data, po_flag, frame_err, work_en);
        end
        rst_n = 1'b1;
        clear_obs();
        repeat (200) @(negedge clk);
        $display("reset released, 200 idle cycles");
        vectors++;
        if ({po_data, po_flag, frame_err, work_en} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_idle: got data=%02h flag=%b err=%b we=%b want 00 0 0 0", po_data, po_flag, frame_err, work_en);
        end
        vectors++;
        if (we_cnt !== 0) begin
            miscompares++;
            $display("FAIL idle_no_start: work_en cycles=%0d want 0", we_cnt);
        end
    endtask

    task automatic test_good_frame();
        int lat;
        clear_obs();
        send_frame(8'hA5, 1'b1);
        repeat (5) @(negedge clk);
        lat = (flag_cyc_q.size() > 0) ? flag_cyc_q[0] - last_e0 : -1;
        vectors++;
        if (flag_cyc_q.size() !== 1) begin
            miscompares++;
            $display("FAIL a5_flag_cycles: got %0d want 1", flag_cyc_q.size());
        end
        vectors++;
        if (lat !== LAT) begin
            miscompares++;
            $display("FAIL a5_latency: got %0d want %0d", lat, LAT);
        end
        vectors++;
        if (po_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL a5_data: got %02h want a5", po_data);
        end
        vectors++;
        if (err_cyc_q.size() !== 0) begin
            miscompares++;
            $display("FAIL a5_no_err: got %0d err pulses want 0", err_cyc_q.size());
        end
    endtask

    task automatic test_frame_error();
        int lat;
        clear_obs();
        send_frame(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        lat = (err_cyc_q.size() > 0) ? err_cyc_q[0] - last_e0 : -1;
        vectors++;
        if (err_cyc_q.size() !== 1) begin
            miscompares++;
            $display("FAIL fe_err_cycles: got %0d want 1", err_cyc_q.size());
        end
        vectors++;
        if (lat !== LAT) begin
            miscompares++;
            $display("FAIL fe_latency: got %0d want %0d", lat, LAT);
        end
        vectors++;
        if (flag_cyc_q.size() !== 0) begin
            miscompares++;
            $display("FAIL fe_no_flag: got %0d flags want 0", flag_cyc_q.size());
        end
        vectors++;
        if (po_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL fe_data_held: got %02h want a5", po_data);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        $display("tx glitch low 3 cycles");
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        vectors++;
        if ((flag_cyc_q.size() + err_cyc_q.size()) !== 0) begin
            miscompares++;
            $display("FAIL glitch_no_strobe: got flags=%0d errs=%0d want 0 0", flag_cyc_q.size(), err_cyc_q.size());
        end
        vectors++;
        if (we_cnt !== GLITCH_WE) begin
            miscompares++;
            $display("FAIL glitch_work_en: got %0d cycles want %0d", we_cnt, GLITCH_WE);
        end
        vectors++;
        if (work_en !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_idle: work_en=%b want 0", work_en);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        clear_obs();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (5) @(negedge clk);
        vectors++;
        if (flag_cyc_q.size() !== 2) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d flags want 2", flag_cyc_q.size());
        end
        gap = (flag_cyc_q.size() >= 2) ? flag_cyc_q[1] - flag_cyc_q[0] : -1;
        vectors++;
        if (gap !== 100) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d want 100", gap);
        end
        vectors++;
        if ((flag_data_q.size() >= 2) ? ({flag_data_q[0], flag_data_q[1]} !== 16'h00FF) : 1'b1) begin
            miscompares++;
            $display("FAIL b2b_data: got %0d bytes first=%02h last=%02h want 00 ff", flag_data_q.size(),
                     (flag_data_q.size() > 0) ? flag_data_q[0] : 8'hxx, (flag_data_q.size() > 1) ? flag_data_q[1] : 8'hxx);
        end
        vectors++;
        if (both_cnt !== 0) begin
            miscompares++;
            $display("FAIL b2b_exclusive: flag and err together %0d times want 0", both_cnt);
        end
    endtask

    task automatic test_break();
        clear_obs();
        $display("tx break low 300 cycles");
        rx = 1'b0;
        repeat (300) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (err_cyc_q.size() !== 1) begin
            miscompares++;
            $display("FAIL break_err_once: got %0d err pulses want 1", err_cyc_q.size());
        end
        vectors++;
        if (flag_cyc_q.size() !== 0) begin
            miscompares++;
            $display("FAIL break_no_flag: got %0d flags want 0", flag_cyc_q.size());
        end
    endtask

    task automatic test_reset_abort();
        logic [9:0] fr;
        int lat;
        clear_obs();
        fr = {1'b1, 8'h5A, 1'b0};
        $display("tx partial frame data=0x5a, reset after bit 3");
        for (int i = 0; i < 5; i++) begin
            rx = fr[i];
            repeat (10) @(negedge clk);
        end
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if ({po_data, work_en} !== 9'h000) begin
            miscompares++;
            $display("FAIL abort_reset_vals: got data=%02h we=%b want 00 0", po_data, work_en);
        end
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        vectors++;
        if ((flag_cyc_q.size() + err_cyc_q.size()) !== 0) begin
            miscompares++;
            $display("FAIL abort_no_strobe: got flags=%0d errs=%0d want 0 0", flag_cyc_q.size(), err_cyc_q.size());
        end
        send_frame(8'h81, 1'b1);
        repeat (5) @(negedge clk);
        lat = (flag_cyc_q.size() > 0) ? flag_cyc_q[0] - last_e0 : -1;
        vectors++;
        if (flag_cyc_q.size() !== 1) begin
            miscompares++;
            $display("FAIL abort_next_flag: got %0d flags want 1", flag_cyc_q.size());
        end
        vectors++;
        if (lat !== LAT) begin
            miscompares++;
            $display("FAIL abort_next_latency: got %0d want %0d", lat, LAT);
        end
        vectors++;
        if (po_data !== 8'h81) begin
            miscompares++;
            $display("FAIL abort_next_data: got %02h want 81", po_data);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_break();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
